// File: rtl/disp_update_sched.sv
// Round-robin arbiter that shares the 7-segment encoder write port between two
// requesters, splitting each 16-bit update into low/high byte writes with per-channel holdoff.
module disp_update_sched #(
    parameter int HOLD_CYCLES = 1000000,
    parameter int HOLD_W      = 20
) (
    input  logic        clk_d,
    input  logic        reset,
    input  logic        req0,
    input  logic [15:0] data0,
    input  logic        req1,
    input  logic [15:0] data1,
    output logic        ack0,
    output logic        ack1,
    output logic [7:0]  disp_out,
    output logic [7:0]  id_port,
    output logic        wr_reg,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, WR_LO, WR_HI, ACK} state_t;

    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);

    state_t            state, state_nx;
    logic              ch, ch_nx;
    logic              last, last_nx;
    logic [7:0]        hi_byte, hi_byte_nx;
    logic [HOLD_W-1:0] hold0, hold1, hold0_nx, hold1_nx;
    logic [7:0]        disp_nx, id_nx;
    logic              wr_nx, ack0_nx, ack1_nx;
    logic              elig0, elig1, grant;

    assign elig0 = req0 && (hold0 == '0);
    assign elig1 = req1 && (hold1 == '0);
    // Channel 1 wins when channel 0 is not eligible, or on a tie when channel 0 was served last.
    assign grant = elig1 && (!elig0 || !last);

    always_comb begin
        state_nx   = state;
        ch_nx      = ch;
        last_nx    = last;
        hi_byte_nx = hi_byte;
        disp_nx    = disp_out;
        id_nx      = id_port;
        wr_nx      = 1'b0;
        ack0_nx    = 1'b0;
        ack1_nx    = 1'b0;
        hold0_nx   = (hold0 != '0) ? hold0 - HOLD_W'(1) : hold0;
        hold1_nx   = (hold1 != '0) ? hold1 - HOLD_W'(1) : hold1;

        case (state)
            IDLE: begin
                if (elig0 || elig1) begin
                    state_nx   = WR_LO;
                    ch_nx      = grant;
                    hi_byte_nx = grant ? data1[15:8] : data0[15:8];
                    wr_nx      = 1'b1;
                    id_nx      = {6'b0, grant, 1'b0};
                    disp_nx    = grant ? data1[7:0] : data0[7:0];
                end
            end
            WR_LO: begin
                state_nx = WR_HI;
                wr_nx    = 1'b1;
                id_nx    = {6'b0, ch, 1'b1};
                disp_nx  = hi_byte;
            end
            WR_HI: begin
                // Holdoff starts in the same cycle the ack becomes visible.
                state_nx = ACK;
                last_nx  = ch;
                if (ch) begin
                    ack1_nx  = 1'b1;
                    hold1_nx = HOLD_LOAD;
                end else begin
                    ack0_nx  = 1'b1;
                    hold0_nx = HOLD_LOAD;
                end
            end
            ACK: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_d) begin
        if (reset) begin
            state    <= IDLE;
            ch       <= 1'b0;
            last     <= 1'b1;
            hi_byte  <= 8'h00;
            hold0    <= '0;
            hold1    <= '0;
            disp_out <= 8'h00;
            id_port  <= 8'h00;
            wr_reg   <= 1'b0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nx;
            ch       <= ch_nx;
            last     <= last_nx;
            hi_byte  <= hi_byte_nx;
            hold0    <= hold0_nx;
            hold1    <= hold1_nx;
            disp_out <= disp_nx;
            id_port  <= id_nx;
            wr_reg   <= wr_nx;
            ack0     <= ack0_nx;
            ack1     <= ack1_nx;
            busy     <= (state_nx != IDLE);
        end
    end

endmodule

// File: tb/tb_disp_update_sched.sv
// Self-checking bench for disp_update_sched: per-cycle vector table plus a
// write/ack scoreboard for the multi-cycle sequences.
module tb_disp_update_sched;

    logic        clk_d = 1'b0;
    logic        reset;
    logic        req0, req1;
    logic [15:0] data0, data1;
    logic        ack0, ack1;
    logic [7:0]  disp_out, id_port;
    logic        wr_reg, busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit sb_en = 1'b0;

    disp_update_sched #(.HOLD_CYCLES(4), .HOLD_W(8)) dut (
        .clk_d(clk_d), .reset(reset),
        .req0(req0), .data0(data0), .req1(req1), .data1(data1),
        .ack0(ack0), .ack1(ack1), .disp_out(disp_out), .id_port(id_port),
        .wr_reg(wr_reg), .busy(busy)
    );

    always #5 clk_d = ~clk_d;
    always @(posedge clk_d) cyc <= cyc + 1;

    typedef struct {
        logic        rst;
        logic        r0;
        logic [15:0] d0;
        logic        r1;
        logic [15:0] d1;
        logic [19:0] exp;
    } vec_t;

    typedef struct packed {
        logic       is_ack;
        logic [7:0] id;
        logic [7:0] dat;
    } sb_t;

    vec_t vecs[23];
    sb_t  sb_q[$];

    function automatic vec_t mk(input logic rst, input logic r0, input logic [15:0] d0,
                                input logic r1, input logic [15:0] d1,
                                input logic wr, input logic [7:0] id, input logic [7:0] dsp,
                                input logic a0, input logic a1, input logic bsy);
        vec_t v;
        v.rst = rst; v.r0 = r0; v.d0 = d0; v.r1 = r1; v.d1 = d1;
        v.exp = {wr, id, dsp, a0, a1, bsy};
        return v;
    endfunction

    task automatic apply_stimulus(input vec_t v);
        reset = v.rst;
        req0  = v.r0;
        data0 = v.d0;
        req1  = v.r1;
        data1 = v.d1;
    endtask

    // Expected layout: {wr_reg, id_port, disp_out, ack0, ack1, busy}
    task automatic check_output(input string name, input logic [19:0] exp);
        logic [19:0] act;
        act = {wr_reg, id_port, disp_out, ack0, ack1, busy};
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got wr/id/disp/a0/a1/busy=%05h, required %05h", name, act, exp);
        end
    endtask

    task automatic push_txn(input logic ch, input logic [15:0] d);
        sb_q.push_back('{1'b0, {6'b0, ch, 1'b0}, d[7:0]});
        sb_q.push_back('{1'b0, {6'b0, ch, 1'b1}, d[15:8]});
        sb_q.push_back('{1'b1, {7'b0, ch}, 8'h00});
    endtask

    function automatic void sb_check(input sb_t got);
        sb_t exp;
        n_checks++;
        if (sb_q.size() == 0) begin
            n_errors++;
            $display("[TB] FAIL sb_unexpected: got ack=%0b id=%02h data=%02h, required no event",
                     got.is_ack, got.id, got.dat);
        end else begin
            exp = sb_q.pop_front();
            if (got !== exp) begin
                n_errors++;
                $display("[TB] FAIL sb_event: got ack=%0b id=%02h data=%02h, required ack=%0b id=%02h data=%02h",
                         got.is_ack, got.id, got.dat, exp.is_ack, exp.id, exp.dat);
            end
        end
    endfunction

    always @(negedge clk_d) begin
        if (sb_en) begin
            if (wr_reg) sb_check('{1'b0, id_port, disp_out});
            if (ack0)   sb_check('{1'b1, 8'h00, 8'h00});
            if (ack1)   sb_check('{1'b1, 8'h01, 8'h00});
        end
    end

    task automatic wait_ack(input logic ch, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk_d);
            if (ch ? ack1 : ack0) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_errors++;
            $display("[TB] FAIL %s: ack%0d not seen within 40 cycles, required within 40", name, ch);
        end
    endtask

    task automatic idle(input int n);
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (n) @(negedge clk_d);
    endtask

    initial begin
        int t_ack, t_wr, k0, k1;
        bit seen;
        logic [15:0] d0s[3];
        logic [15:0] d1s[3];

        // Reset with both requests up, tie, single update with mid-write data change, holdoff + interleave.
        vecs[0]  = mk(1'b1, 1'b1, 16'hABCD, 1'b1, 16'h5678, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        vecs[1]  = mk(1'b1, 1'b1, 16'hABCD, 1'b1, 16'h5678, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        vecs[2]  = mk(1'b1, 1'b1, 16'hABCD, 1'b1, 16'h5678, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        vecs[3]  = mk(1'b0, 1'b1, 16'hABCD, 1'b1, 16'h5678, 1'b1, 8'h00, 8'hCD, 1'b0, 1'b0, 1'b1);
        vecs[4]  = mk(1'b0, 1'b1, 16'hABCD, 1'b1, 16'h5678, 1'b1, 8'h01, 8'hAB, 1'b0, 1'b0, 1'b1);
        vecs[5]  = mk(1'b0, 1'b1, 16'hABCD, 1'b1, 16'h5678, 1'b0, 8'h01, 8'hAB, 1'b1, 1'b0, 1'b1);
        vecs[6]  = mk(1'b0, 1'b0, 16'hABCD, 1'b1, 16'h5678, 1'b0, 8'h01, 8'hAB, 1'b0, 1'b0, 1'b0);
        vecs[7]  = mk(1'b0, 1'b0, 16'hABCD, 1'b1, 16'h5678, 1'b1, 8'h02, 8'h78, 1'b0, 1'b0, 1'b1);
        vecs[8]  = mk(1'b0, 1'b0, 16'hABCD, 1'b1, 16'h5678, 1'b1, 8'h03, 8'h56, 1'b0, 1'b0, 1'b1);
        vecs[9]  = mk(1'b0, 1'b0, 16'hABCD, 1'b1, 16'h5678, 1'b0, 8'h03, 8'h56, 1'b0, 1'b1, 1'b1);
        vecs[10] = mk(1'b0, 1'b0, 16'hABCD, 1'b0, 16'h5678, 1'b0, 8'h03, 8'h56, 1'b0, 1'b0, 1'b0);
        vecs[11] = mk(1'b0, 1'b1, 16'h1234, 1'b0, 16'h5678, 1'b1, 8'h00, 8'h34, 1'b0, 1'b0, 1'b1);
        vecs[12] = mk(1'b0, 1'b1, 16'hFFFF, 1'b0, 16'h5678, 1'b1, 8'h01, 8'h12, 1'b0, 1'b0, 1'b1);
        vecs[13] = mk(1'b0, 1'b1, 16'hFFFF, 1'b0, 16'h5678, 1'b0, 8'h01, 8'h12, 1'b1, 1'b0, 1'b1);
        vecs[14] = mk(1'b0, 1'b1, 16'hFFFF, 1'b0, 16'h5678, 1'b0, 8'h01, 8'h12, 1'b0, 1'b0, 1'b0);
        vecs[15] = mk(1'b0, 1'b1, 16'hFFFF, 1'b1, 16'h0A0B, 1'b1, 8'h02, 8'h0B, 1'b0, 1'b0, 1'b1);
        vecs[16] = mk(1'b0, 1'b1, 16'hFFFF, 1'b1, 16'h0A0B, 1'b1, 8'h03, 8'h0A, 1'b0, 1'b0, 1'b1);
        vecs[17] = mk(1'b0, 1'b1, 16'hFFFF, 1'b1, 16'h0A0B, 1'b0, 8'h03, 8'h0A, 1'b0, 1'b1, 1'b1);
        vecs[18] = mk(1'b0, 1'b1, 16'hFFFF, 1'b0, 16'h0A0B, 1'b0, 8'h03, 8'h0A, 1'b0, 1'b0, 1'b0);
        vecs[19] = mk(1'b0, 1'b1, 16'hFFFF, 1'b0, 16'h0A0B, 1'b1, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b1);
        vecs[20] = mk(1'b0, 1'b1, 16'hFFFF, 1'b0, 16'h0A0B, 1'b1, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b1);
        vecs[21] = mk(1'b0, 1'b1, 16'hFFFF, 1'b0, 16'h0A0B, 1'b0, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b1);
        vecs[22] = mk(1'b0, 1'b0, 16'hFFFF, 1'b0, 16'h0A0B, 1'b0, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 23; i++) begin
            apply_stimulus(vecs[i]);
            @(negedge clk_d);
            check_output($sformatf("vec%0d", i), vecs[i].exp);
        end

        sb_en = 1'b1;
        idle(8);

        // Reset lands in the WR_HI cycle: both bytes appear, ack is suppressed, then a full re-serve.
        data0 = 16'h4321;
        req0  = 1'b1;
        sb_q.push_back('{1'b0, 8'h00, 8'h21});
        sb_q.push_back('{1'b0, 8'h01, 8'h43});
        @(negedge clk_d);
        @(negedge clk_d);
        reset = 1'b1;
        @(negedge clk_d);
        check_output("rst_wrhi", 20'h00000);
        push_txn(1'b0, 16'h4321);
        reset = 1'b0;
        wait_ack(1'b0, "rst_reserve");
        req0 = 1'b0;
        idle(8);

        // Channel 0 held high across its own ack: next WR_LO comes exactly 5 cycles after the ack.
        data0 = 16'h0F0E;
        req0  = 1'b1;
        push_txn(1'b0, 16'h0F0E);
        push_txn(1'b0, 16'h0F0E);
        wait_ack(1'b0, "hold_first");
        t_ack = cyc;
        seen  = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk_d);
            if (wr_reg) seen = 1'b1;
        end
        t_wr = cyc;
        n_checks++;
        if (!seen || (t_wr - t_ack) != 5) begin
            n_errors++;
            $display("[TB] FAIL hold_gap: got %0d cycles (seen=%0b), required 5", t_wr - t_ack, seen);
        end
        wait_ack(1'b0, "hold_second");
        req0 = 1'b0;
        idle(8);

        // Both channels continuously requesting: grants alternate starting with channel 1.
        for (int i = 0; i < 3; i++) begin
            d0s[i] = 16'($urandom);
            d1s[i] = 16'($urandom);
        end
        for (int i = 0; i < 3; i++) begin
            push_txn(1'b1, d1s[i]);
            push_txn(1'b0, d0s[i]);
        end
        data0 = d0s[0];
        data1 = d1s[0];
        req0  = 1'b1;
        req1  = 1'b1;
        k0 = 0;
        k1 = 0;
        for (int i = 0; i < 120 && (k0 < 3 || k1 < 3); i++) begin
            @(negedge clk_d);
            if (ack0) begin
                k0++;
                if (k0 == 3) req0 = 1'b0; else data0 = d0s[k0];
            end
            if (ack1) begin
                k1++;
                if (k1 == 3) req1 = 1'b0; else data1 = d1s[k1];
            end
        end
        n_checks++;
        if (k0 < 3 || k1 < 3) begin
            n_errors++;
            $display("[TB] FAIL alt_done: got acks ch0=%0d ch1=%0d, required 3 each", k0, k1);
        end
        idle(4);

        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("[TB] FAIL sb_drain: got %0d pending events, required 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/disp_update_sched.md
Name: disp_update_sched

Overview:
- Round-robin scheduler that shares the 7-segment display register write port between two hardware requesters.
- Each requester owns one 4-digit display: channel 0 → ports 0x00/0x01, channel 1 → ports 0x02/0x03.
- Converts a 16-bit BCD/hex update into two byte writes on the Disp/id_port/wr_reg interface of the 7-segment encoder.
- A per-channel holdoff limits how often a display can be rewritten, so fast-changing sources don't cause flicker.

Parameters:
- HOLD_CYCLES, 1000000, minimum clk_d cycles from a channel's ack until that channel can be granted again (10 ms at 100 MHz); 0 disables holdoff.
- HOLD_W, 20, width of the holdoff counters; HOLD_CYCLES must be < 2^HOLD_W.

Ports:
- clk_d  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req0  input  1  channel 0 update request; held until ack0.
- data0  input  16  channel 0 value: [3:0] rightmost digit … [15:12] leftmost digit.
- req1  input  1  channel 1 update request; held until ack1.
- data1  input  16  channel 1 value, same digit order.
- ack0  output  1  one-cycle pulse: channel 0 update written.
- ack1  output  1  one-cycle pulse: channel 1 update written.
- disp_out  output  8  byte to the encoder Disp input.
- id_port  output  8  port address to the encoder.
- wr_reg  output  1  write strobe to the encoder.
- busy  output  1  high while state != IDLE.

Behaviour:
- Reset: clock clk_d; reset is synchronous, active-high, and dominates all other inputs.
  - State → IDLE.
  - All outputs → 0: disp_out=0x00, id_port=0x00, wr_reg=0, ack0=0, ack1=0, busy=0.
  - Both holdoff counters → 0.
  - Round-robin pointer last → 1, so channel 0 wins the first tie.
- All outputs are registered.
- Eligibility: channel i is eligible when req_i=1 and hold_i=0.
- FSM states: IDLE, WR_LO, WR_HI, ACK.
  - IDLE:
    - No eligible channel: stay in IDLE; wr_reg=0, ack=0.
    - One eligible channel: grant it.
    - Both eligible: grant the channel != last.
    - On grant: latch ch := granted index and buf := data_ch; go to WR_LO.
  - WR_LO (1 cycle): wr_reg=1, id_port={6'b0,ch,1'b0}, disp_out=buf[7:0]; go to WR_HI.
  - WR_HI (1 cycle): wr_reg=1, id_port={6'b0,ch,1'b1}, disp_out=buf[15:8]; go to ACK.
  - ACK (1 cycle): wr_reg=0, ack_ch=1, last:=ch, hold_ch:=HOLD_CYCLES; go to IDLE.
- Disp_out/id_port outside WR_LO and WR_HI keep their last values; consumers must ignore them while wr_reg=0.
- Timing: with a grant sampled at edge n, WR_LO outputs are valid in cycle n+1, WR_HI in n+2 and ack in n+3. IDLE is re-entered in n+4, so the minimum period is 4 cycles per update.
- Data is latched at grant. Changes on data_i after the grant do not affect the update in progress.
- Handshake:
  - A requester may drop req only after ack, or while not granted; dropping it before grant withdraws the request without side effects.
  - If req_i is still 1 in the cycle after ack_i, it is a new request, subject to holdoff.
- Holdoff:
  - Each counter decrements by 1 per cycle while nonzero, in every state.
  - The ungranted channel's counter keeps decrementing during the other channel's transaction.
  - With HOLD_CYCLES=0, the same channel can be granted again in the IDLE cycle right after ACK.
- Starvation-free: while both channels are continuously eligible, grants alternate 0,1,0,1.
- A request arriving during a transaction waits in IDLE arbitration; it is never lost while req stays high.
- Reset mid-transaction:
  - The FSM aborts to IDLE with no ack.
  - If WR_LO was already issued, the low byte stays in the encoder. The requester must re-request after reset.

Test Plan:
- Reset: hold reset 3 cycles with req0=req1=1 → all outputs 0, no wr_reg pulse; first grant after release goes to channel 0.
- Single update (HOLD_CYCLES=4): req0=1, data0=0x1234 → next cycle wr_reg=1/id 0x00/disp 0x34, then id 0x01/disp 0x12, then ack0 for 1 cycle with wr_reg=0; busy high for 3 cycles.
- Tie: req0 (0xABCD) and req1 (0x5678) both rise in the same cycle → writes in order (00,CD),(01,AB),ack0,(02,78),(03,56),ack1; second grant in the IDLE cycle after ack0.
- Holdoff (HOLD_CYCLES=4): req0 held high after ack0 with req1=0 → next channel 0 grant no earlier than 4 cycles after ack0; if req1 rises meanwhile, channel 1 is granted at the first IDLE cycle.
- Data stability: data0 changes 0x1234→0xFFFF during WR_LO → WR_HI still drives 0x12.
- Reset during WR_HI: reset asserted in the WR_HI cycle → next cycle all outputs 0, state IDLE, no ack0; after release, a still-asserted req0 is re-served in full.
